// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared ControlUnit definitions used by the cycle sequencer and the
// instruction-group decoders that consume its timing buses.
//   - DEFAULT_N_STEPS / DEFAULT_N_MCYCLES : default widths of the step and
//     M-cycle one-hot buses
//   - STEP_T1..STEP_T4 : one-hot T-step encodings for the default 4-step bus
//   - MCYCLE_FIRST     : one-hot code of the first M-cycle of an instruction
//   - seq_state_t      : sequencer state encoding
// ---------------------------------------------------------------------------
package ctrl_pkg;

   localparam int DEFAULT_N_STEPS   = 4;
   localparam int DEFAULT_N_MCYCLES = 8;

   localparam logic [3:0] STEP_T1 = 4'b0001;
   localparam logic [3:0] STEP_T2 = 4'b0010;
   localparam logic [3:0] STEP_T3 = 4'b0100;
   localparam logic [3:0] STEP_T4 = 4'b1000;

   localparam logic [7:0] MCYCLE_FIRST = 8'b0000_0001;

   // SEQ_WAKE is the first M-cycle after leaving HALT; it behaves like
   // SEQ_RUN except that the opcode fetch is forced at the end of it.
   typedef enum logic [1:0] {
      SEQ_RUN    = 2'd0,
      SEQ_HALTED = 2'd1,
      SEQ_WAKE   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/onehot_ring.sv
// ---------------------------------------------------------------------------
// onehot_ring
// One-hot rotate register used for both the T-step bus and the M-cycle bus.
// Priority per clock: hold > load_first > advance.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset, value returns to bit 0
//   hold       : freeze the register for this clock
//   load_first : synchronously load the one-hot code of bit 0
//   advance    : rotate left by one position (top bit wraps to bit 0)
//   value      : current one-hot value
//   wrap       : combinational flag, this clock's advance leaves the top bit
// ---------------------------------------------------------------------------
module onehot_ring
   import ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_N_STEPS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             load_first,
   input  logic             advance,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] FIRST = {{(WIDTH-1){1'b0}}, 1'b1};

   // The ring always holds exactly one set bit; rotating (rather than
   // shifting) keeps it one-hot even when the owner lets it run off the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= FIRST;
      end else if (hold) begin
         value <= value;
      end else if (load_first) begin
         value <= FIRST;
      end else if (advance) begin
         value <= {value[WIDTH-2:0], value[WIDTH-1]};
      end
   end

   // Wrap is only reported for a real rotation out of the top bit, so an
   // explicit reload or a frozen cycle never looks like an overflow.
   assign wrap = advance & ~hold & ~load_first & value[WIDTH-1];

endmodule

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
// Timing generator for the instruction-group decoders. Produces the one-hot
// T-step and M-cycle buses, ends instructions on the decoders' fetch request,
// loads IR, and handles entry to and exit from HALT.
//
// Optional feature macro: CYCLE_SEQ_HALT_BUG_EN
//   Defined   : HALT with IME=0 and an interrupt already pending skips HALTED
//               and raises o_PC_Inc_Inhibit for the whole wake M-cycle
//               (DMG halt bug, the byte after HALT is read twice).
//   Undefined : the same path goes to wake, o_PC_Inc_Inhibit stays 0.
//
// Ports:
//   i_Clk            : system clock
//   i_Reset_n        : asynchronous active-low reset
//   i_IR_Fetch       : OR of decoder fetch requests, current M-cycle is last
//   i_Halt           : OR of decoder halt requests, valid in the last T-step
//   i_Wait           : bus wait, freezes sequencing (ignored while HALTED)
//   i_Int_Pending    : (IE & IF) != 0
//   i_IME            : interrupt master enable
//   o_Cycle_Step     : one-hot T-step (all zero while HALTED)
//   o_Cycle_Count    : one-hot M-cycle index
//   o_IR_Load        : one-clock pulse, latch the data bus into IR
//   o_Force_Fetch    : high for the whole first M-cycle after a HALT exit
//   o_Halted         : sequencer is in HALTED
//   o_PC_Inc_Inhibit : halt-bug indication
//   o_Seq_Error      : sticky M-cycle overflow flag
// ---------------------------------------------------------------------------
module cycle_sequencer
   import ctrl_pkg::*;
#(
   parameter int N_STEPS   = DEFAULT_N_STEPS,
   parameter int N_MCYCLES = DEFAULT_N_MCYCLES
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset_n,
   input  logic                 i_IR_Fetch,
   input  logic                 i_Halt,
   input  logic                 i_Wait,
   input  logic                 i_Int_Pending,
   input  logic                 i_IME,
   output logic [N_STEPS-1:0]   o_Cycle_Step,
   output logic [N_MCYCLES-1:0] o_Cycle_Count,
   output logic                 o_IR_Load,
   output logic                 o_Force_Fetch,
   output logic                 o_Halted,
   output logic                 o_PC_Inc_Inhibit,
   output logic                 o_Seq_Error
);

   seq_state_t state, state_next;

   logic [N_STEPS-1:0]   step_q;
   logic [N_MCYCLES-1:0] count_q;

   logic wake_armed, wake_armed_next;
   logic inhibit, inhibit_next;
   logic seq_error;

   logic ring_hold;
   logic step_adv, step_load, step_wrap;
   logic count_adv, count_load, count_wrap;
   logic fetch_now;
   logic ir_load;
   logic halt_bug;

   // Wait freezes both rings together; HALTED ignores wait so an interrupt
   // can always pull the sequencer out of HALT.
   assign ring_hold = i_Wait & (state != SEQ_HALTED);

   // The wake M-cycle always ends with an opcode fetch so the HALT opcode
   // still sitting in IR is never executed a second time.
   assign fetch_now = i_IR_Fetch | (state == SEQ_WAKE);

`ifdef CYCLE_SEQ_HALT_BUG_EN
   assign halt_bug = ~i_IME;
`else
   logic unused_ime;
   assign unused_ime = i_IME;
   assign halt_bug   = 1'b0;
`endif

   onehot_ring #(.WIDTH(N_STEPS)) u_step_ring (
      .clk        (i_Clk),
      .rst_n      (i_Reset_n),
      .hold       (ring_hold),
      .load_first (step_load),
      .advance    (step_adv),
      .value      (step_q),
      .wrap       (step_wrap)
   );

   onehot_ring #(.WIDTH(N_MCYCLES)) u_count_ring (
      .clk        (i_Clk),
      .rst_n      (i_Reset_n),
      .hold       (ring_hold),
      .load_first (count_load),
      .advance    (count_adv),
      .value      (count_q),
      .wrap       (count_wrap)
   );

   // Next-state and ring control. The step ring rotates every running clock;
   // its wrap flag marks the last T-step of an M-cycle, which is the only
   // point where fetch, halt or the M-cycle advance take effect. Using the
   // wrap flag (which already includes hold) keeps IR_Load off during wait.
   always_comb begin
      state_next      = state;
      wake_armed_next = 1'b0;
      inhibit_next    = inhibit;
      step_adv        = 1'b0;
      step_load       = 1'b0;
      count_adv       = 1'b0;
      count_load      = 1'b0;
      ir_load         = 1'b0;

      case (state)
         SEQ_RUN, SEQ_WAKE: begin
            step_adv = 1'b1;
            if (step_wrap) begin
               if (fetch_now) begin
                  // Fetch wins over a simultaneous halt request.
                  ir_load      = 1'b1;
                  count_load   = 1'b1;
                  state_next   = SEQ_RUN;
                  inhibit_next = 1'b0;
               end else if (i_Halt) begin
                  count_load = 1'b1;
                  if (!i_Int_Pending) begin
                     state_next   = SEQ_HALTED;
                     inhibit_next = 1'b0;
                  end else begin
                     state_next   = SEQ_WAKE;
                     inhibit_next = halt_bug;
                  end
               end else begin
                  count_adv = 1'b1;
               end
            end
         end

         SEQ_HALTED: begin
            // Rings are parked at their first position so the wake M-cycle
            // starts cleanly. The interrupt is registered for one clock
            // before leaving, giving the two-edge wake latency.
            step_load       = 1'b1;
            count_load      = 1'b1;
            inhibit_next    = 1'b0;
            wake_armed_next = i_Int_Pending;
            if (wake_armed) begin
               state_next = SEQ_WAKE;
            end
         end

         default: begin
            state_next   = SEQ_RUN;
            step_load    = 1'b1;
            count_load   = 1'b1;
            inhibit_next = 1'b0;
         end
      endcase
   end

   // State register plus the wake arm, halt-bug and overflow flags. The
   // overflow flag is sticky: only reset clears it.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state      <= SEQ_RUN;
         wake_armed <= 1'b0;
         inhibit    <= 1'b0;
         seq_error  <= 1'b0;
      end else begin
         state      <= state_next;
         wake_armed <= wake_armed_next;
         inhibit    <= inhibit_next;
         seq_error  <= seq_error | count_wrap;
      end
   end

   // Step bus is gated to zero while halted so every decoder goes idle.
   // Without the halt-bug build the inhibit register never sets and folds
   // away to a constant 0.
   assign o_Cycle_Step     = (state == SEQ_HALTED) ? '0 : step_q;
   assign o_Cycle_Count    = count_q;
   assign o_IR_Load        = ir_load;
   assign o_Force_Fetch    = (state == SEQ_WAKE);
   assign o_Halted         = (state == SEQ_HALTED);
   assign o_PC_Inc_Inhibit = inhibit;
   assign o_Seq_Error      = seq_error;

endmodule

// File: tb/tb_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cycle_sequencer
// Directed bench for cycle_sequencer. Each step drives inputs on the falling
// edge, pushes the expected outputs for that clock into a scoreboard queue,
// then pops and compares shortly after. Honours CYCLE_SEQ_HALT_BUG_EN for
// the halt-bug expectation.
// ---------------------------------------------------------------------------
module tb_cycle_sequencer;

   typedef struct packed {
      logic [3:0] step;
      logic [7:0] count;
      logic       ir;
      logic       ff;
      logic       halted;
      logic       inh;
      logic       err;
   } exp_t;

`ifdef CYCLE_SEQ_HALT_BUG_EN
   localparam logic BUG = 1'b1;
`else
   localparam logic BUG = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       ir_fetch;
   logic       halt;
   logic       wt;
   logic       int_pending;
   logic       ime;
   logic [3:0] cycle_step;
   logic [7:0] cycle_count;
   logic       ir_load;
   logic       force_fetch;
   logic       halted;
   logic       pc_inc_inhibit;
   logic       seq_error;

   exp_t  exp_q[$];
   string tag_q[$];
   int    compare_count = 0;
   int    fail_count    = 0;

   cycle_sequencer dut (
      .i_Clk            (clk),
      .i_Reset_n        (rst_n),
      .i_IR_Fetch       (ir_fetch),
      .i_Halt           (halt),
      .i_Wait           (wt),
      .i_Int_Pending    (int_pending),
      .i_IME            (ime),
      .o_Cycle_Step     (cycle_step),
      .o_Cycle_Count    (cycle_count),
      .o_IR_Load        (ir_load),
      .o_Force_Fetch    (force_fetch),
      .o_Halted         (halted),
      .o_PC_Inc_Inhibit (pc_inc_inhibit),
      .o_Seq_Error      (seq_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] s, input logic [7:0] c,
                               input logic ir, input logic ff,
                               input logic h, input logic inh,
                               input logic err);
      exp_t e;
      e.step   = s;
      e.count  = c;
      e.ir     = ir;
      e.ff     = ff;
      e.halted = h;
      e.inh    = inh;
      e.err    = err;
      return e;
   endfunction

   // Pop the oldest expectation and compare it against the live outputs.
   task automatic checkOutput();
      exp_t  e;
      exp_t  obs;
      string t;
      obs = {cycle_step, cycle_count, ir_load, force_fetch, halted,
             pc_inc_inhibit, seq_error};
      compare_count++;
      if (exp_q.size() == 0) begin
         fail_count++;
         $error("[TB] FAIL scoreboard_empty observed=%h required=entry", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h required=%h", t, obs, e);
         end
      end
   endtask

   // iv = {ir_fetch, halt, wait, int_pending, ime}; expectation is for the
   // outputs during this clock, before the next rising edge.
   task automatic applyStimulus(input logic [4:0] iv, input exp_t e,
                                input string t);
      @(negedge clk);
      {ir_fetch, halt, wt, int_pending, ime} = iv;
      exp_q.push_back(e);
      tag_q.push_back(t);
      #1;
      checkOutput();
   endtask

   // Asserts reset mid-cycle, checks the reset values asynchronously, then
   // releases with iv already applied for the following rising edge.
   task automatic applyReset(input logic [4:0] iv, input string t);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      {ir_fetch, halt, wt, int_pending, ime} = iv;
      exp_q.push_back(mk(4'b0001, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      tag_q.push_back(t);
      #1;
      checkOutput();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      ir_fetch    = 1'b0;
      halt        = 1'b0;
      wt          = 1'b0;
      int_pending = 1'b0;
      ime         = 1'b0;

      // Reset, then single-M-cycle instructions (fetch always high).
      applyReset(5'b10000, "reset");
      for (int i = 1; i < 8; i++)
         applyStimulus(5'b10000,
            mk(4'(1 << (i % 4)), 8'h01, (i % 4) == 3, 1'b0, 1'b0, 1'b0, 1'b0),
            $sformatf("t1_free_run%0d", i));

      // Three-M-cycle instruction, fetch only during the third M-cycle.
      for (int i = 0; i < 12; i++)
         applyStimulus({(i >= 8), 4'b0000},
            mk(4'(1 << (i % 4)), 8'(1 << (i / 4)), i == 11, 1'b0, 1'b0, 1'b0, 1'b0),
            $sformatf("t2_three_m%0d", i));

      // Wait at T3 for three clocks, then at T4 for two clocks.
      applyStimulus(5'b10000, mk(4'b0001, 8'h01, 0, 0, 0, 0, 0), "t3_s1");
      applyStimulus(5'b10000, mk(4'b0010, 8'h01, 0, 0, 0, 0, 0), "t3_s2");
      for (int i = 0; i < 3; i++)
         applyStimulus(5'b10100, mk(4'b0100, 8'h01, 0, 0, 0, 0, 0),
                       $sformatf("t3_wait_t3_%0d", i));
      applyStimulus(5'b10000, mk(4'b0100, 8'h01, 0, 0, 0, 0, 0), "t3_s3");
      for (int i = 0; i < 2; i++)
         applyStimulus(5'b10100, mk(4'b1000, 8'h01, 0, 0, 0, 0, 0),
                       $sformatf("t3_wait_t4_%0d", i));
      applyStimulus(5'b10000, mk(4'b1000, 8'h01, 1, 0, 0, 0, 0), "t3_s4_load");

      // HALT with no interrupt pending, 20 halted clocks, then wake.
      applyStimulus(5'b00000, mk(4'b0001, 8'h01, 0, 0, 0, 0, 0), "t4_s1");
      applyStimulus(5'b00000, mk(4'b0010, 8'h01, 0, 0, 0, 0, 0), "t4_s2");
      applyStimulus(5'b00000, mk(4'b0100, 8'h01, 0, 0, 0, 0, 0), "t4_s3");
      applyStimulus(5'b01000, mk(4'b1000, 8'h01, 0, 0, 0, 0, 0), "t4_halt_req");
      for (int i = 0; i < 20; i++)
         applyStimulus({2'b00, 1'(i % 2), 2'b00},
                       mk(4'b0000, 8'h01, 0, 0, 1, 0, 0),
                       $sformatf("t4_halted%0d", i));
      applyStimulus(5'b00010, mk(4'b0000, 8'h01, 0, 0, 1, 0, 0), "t4_int_rise");
      applyStimulus(5'b00000, mk(4'b0000, 8'h01, 0, 0, 1, 0, 0), "t4_int_edge1");
      for (int i = 0; i < 4; i++)
         applyStimulus(5'b00000,
            mk(4'(1 << i), 8'h01, i == 3, 1'b1, 1'b0, 1'b0, 1'b0),
            $sformatf("t4_wake%0d", i));

      // HALT with interrupt already pending, IME=0 (halt bug) then IME=1.
      for (int pass = 0; pass < 2; pass++) begin
         applyStimulus(5'b00000, mk(4'b0001, 8'h01, 0, 0, 0, 0, 0),
                       $sformatf("t5_%0d_s1", pass));
         applyStimulus(5'b00000, mk(4'b0010, 8'h01, 0, 0, 0, 0, 0),
                       $sformatf("t5_%0d_s2", pass));
         applyStimulus(5'b00000, mk(4'b0100, 8'h01, 0, 0, 0, 0, 0),
                       $sformatf("t5_%0d_s3", pass));
         applyStimulus({4'b0101, 1'(pass)}, mk(4'b1000, 8'h01, 0, 0, 0, 0, 0),
                       $sformatf("t5_%0d_halt_req", pass));
         for (int i = 0; i < 4; i++)
            applyStimulus(5'b00000,
               mk(4'(1 << i), 8'h01, i == 3, 1'b1, 1'b0,
                  (pass == 0) ? BUG : 1'b0, 1'b0),
               $sformatf("t5_%0d_wake%0d", pass, i));
      end

      // Eight M-cycles with no fetch: count overflows, error goes sticky.
      for (int i = 0; i < 32; i++)
         applyStimulus(5'b00000,
            mk(4'(1 << (i % 4)), 8'(1 << (i / 4)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
            $sformatf("t6_overflow%0d", i));
      for (int i = 0; i < 4; i++)
         applyStimulus(5'b10000,
            mk(4'(1 << i), 8'h01, i == 3, 1'b0, 1'b0, 1'b0, 1'b1),
            $sformatf("t6_sticky%0d", i));

      // Halt again, then reset asynchronously while halted.
      applyStimulus(5'b00000, mk(4'b0001, 8'h01, 0, 0, 0, 0, 1), "t7_s1");
      applyStimulus(5'b00000, mk(4'b0010, 8'h01, 0, 0, 0, 0, 1), "t7_s2");
      applyStimulus(5'b00000, mk(4'b0100, 8'h01, 0, 0, 0, 0, 1), "t7_s3");
      applyStimulus(5'b01000, mk(4'b1000, 8'h01, 0, 0, 0, 0, 1), "t7_halt_req");
      for (int i = 0; i < 3; i++)
         applyStimulus(5'b00000, mk(4'b0000, 8'h01, 0, 0, 1, 0, 1),
                       $sformatf("t7_halted%0d", i));
      applyReset(5'b10000, "t7_reset_halted");
      applyStimulus(5'b10000, mk(4'b0010, 8'h01, 0, 0, 0, 0, 0), "t7_post_s2");
      applyStimulus(5'b10000, mk(4'b0100, 8'h01, 0, 0, 0, 0, 0), "t7_post_s3");
      applyStimulus(5'b10000, mk(4'b1000, 8'h01, 1, 0, 0, 0, 0), "t7_post_s4");

      if (exp_q.size() != 0) begin
         fail_count++;
         $error("[TB] FAIL scoreboard_leftover observed=%0d required=0",
                exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compare_count, fail_count);
      $finish;
   end

endmodule
